// File: rtl/cups_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cups_pkg                                                                   |
// | Shared definitions for the 16-bit five-stage core hazard logic:            |
// | register-index width, the "no destination" register index and the         |
// | hazard controller state encoding.                                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package cups_pkg;

  localparam int REG_IDX_W = 3;

  // Destination index 0 marks an instruction that writes no register.
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 3'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_detect                                                              |
// | Combinational load-use comparator. Flags when the instruction in ID reads  |
// | a register that the load currently in EX is about to write.                |
// | Ports:                                                                     |
// |   idRs1, idRs2   in  source register indices of the ID instruction         |
// |   idUse1, idUse2 in  the matching source is actually read                  |
// |   idexR          in  instruction in EX is a load                           |
// |   idexregWrite   in  destination of the EX instruction (0 = none)          |
// |   hazard         out load-use hazard present                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_detect
  import cups_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idRs1,
  input  logic [REG_IDX_W-1:0] idRs2,
  input  logic                 idUse1,
  input  logic                 idUse2,
  input  logic                 idexR,
  input  logic [REG_IDX_W-1:0] idexregWrite,
  output logic                 hazard
);

  logic load_writes;
  logic src1_hit;
  logic src2_hit;

  assign load_writes = idexR && (idexregWrite != REG_ZERO);
  assign src1_hit    = idUse1 && (idRs1 == idexregWrite);
  assign src2_hit    = idUse2 && (idRs2 == idexregWrite);
  assign hazard      = load_writes && (src1_hit || src2_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl                                                                |
// | Pipeline hazard controller. Sequences load-use bubbles, taken-branch       |
// | flushes and multi-cycle memory waits; all enables are Mealy outputs of the |
// | current state and inputs. Keeps a saturating stall-cycle counter.          |
// | Ports:                                                                     |
// |   clk, reset          core clock / async active-low reset                  |
// |   idRs1/2, idUse1/2   ID-stage sources                                     |
// |   idexR, idexregWrite EX-stage load flag and destination                   |
// |   exBranchTaken       branch/jump resolved taken in EX                     |
// |   memReq, memReady    MEM-stage handshake                                  |
// |   pcWrite, ifidWrite  PC / IF-ID load enables                              |
// |   ifidFlush           clear IF/ID to a NOP                                 |
// |   idexStall           load a bubble into ID/EX                             |
// |   freeze              hold every pipeline register                         |
// |   memErr              one-cycle pulse on memory timeout                    |
// |   stallCount          saturating stall/flush/freeze cycle count            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_ctrl
  import cups_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 8,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   idRs1,
  input  logic [REG_IDX_W-1:0]   idRs2,
  input  logic                   idUse1,
  input  logic                   idUse2,
  input  logic                   idexR,
  input  logic [REG_IDX_W-1:0]   idexregWrite,
  input  logic                   exBranchTaken,
  input  logic                   memReq,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   ifidWrite,
  output logic                   ifidFlush,
  output logic                   idexStall,
  output logic                   freeze,
  output logic                   memErr,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0]        BUB_LAST  = 2'(LOAD_BUBBLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

  state_e                 state_q, state_d;
  logic [1:0]             bub_q, bub_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic              hazard;
  logic              mem_busy;
  logic              run_decode;
  logic [1:0]        bub_inc;
  logic [WAIT_W-1:0] wait_inc;

  // Decoded enables before the reset override is applied.
  logic pc_dec, ifid_dec, flush_dec, stall_dec, freeze_dec, err_dec;
  logic any_stall;

  hazard_detect u_detect (
    .idRs1        (idRs1),
    .idRs2        (idRs2),
    .idUse1       (idUse1),
    .idUse2       (idUse2),
    .idexR        (idexR),
    .idexregWrite (idexregWrite),
    .hazard       (hazard)
  );

  assign mem_busy = memReq && !memReady;
  assign bub_inc  = bub_q + 2'd1;
  assign wait_inc = wait_q + WAIT_W'(1);

  always_comb begin
    state_d    = state_q;
    bub_d      = bub_q;
    wait_d     = wait_q;
    pc_dec     = 1'b1;
    ifid_dec   = 1'b1;
    flush_dec  = 1'b0;
    stall_dec  = 1'b0;
    freeze_dec = 1'b0;
    err_dec    = 1'b0;
    run_decode = 1'b0;

    case (state_q)
      RUN: run_decode = 1'b1;

      LOAD_STALL: begin
        pc_dec   = 1'b0;
        ifid_dec = 1'b0;
        if (mem_busy) begin
          // Memory wait overrides the bubble; bubble progress is held.
          freeze_dec = 1'b1;
        end else begin
          stall_dec = 1'b1;
          bub_d     = bub_inc;
          if (bub_inc == BUB_LAST) begin
            state_d = RUN;
            bub_d   = 2'd0;
          end
        end
      end

      MEM_WAIT: begin
        if (!mem_busy) begin
          // Released (or memReq dropped): the pipeline is live again this
          // cycle, so decode branches and hazards as in RUN.
          state_d    = RUN;
          wait_d     = '0;
          run_decode = 1'b1;
        end else if (wait_inc == WAIT_LAST) begin
          err_dec = 1'b1;
          state_d = RUN;
          wait_d  = '0;
        end else begin
          freeze_dec = 1'b1;
          pc_dec     = 1'b0;
          ifid_dec   = 1'b0;
          wait_d     = wait_inc;
        end
      end

      default: state_d = RUN;
    endcase

    if (run_decode) begin
      if (mem_busy) begin
        freeze_dec = 1'b1;
        pc_dec     = 1'b0;
        ifid_dec   = 1'b0;
        wait_d     = WAIT_W'(1);
        state_d    = MEM_WAIT;
      end else if (exBranchTaken) begin
        // The flush squashes the dependent instruction, so no bubble needed.
        flush_dec = 1'b1;
        stall_dec = 1'b1;
        pc_dec    = 1'b1;
      end else if (hazard) begin
        pc_dec    = 1'b0;
        ifid_dec  = 1'b0;
        stall_dec = 1'b1;
        bub_d     = 2'd1;
        if (LOAD_BUBBLES > 1) begin
          state_d = LOAD_STALL;
        end
      end
    end
  end

  assign any_stall = freeze_dec || stall_dec || flush_dec;

  always_comb begin
    cnt_d = cnt_q;
    if (any_stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      bub_q   <= 2'd0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is low the pipeline is held with a bubble/NOP injected.
  assign pcWrite    = reset ? pc_dec     : 1'b0;
  assign ifidWrite  = reset ? ifid_dec   : 1'b0;
  assign ifidFlush  = reset ? flush_dec  : 1'b1;
  assign idexStall  = reset ? stall_dec  : 1'b1;
  assign freeze     = reset ? freeze_dec : 1'b0;
  assign memErr     = reset ? err_dec    : 1'b0;
  assign stallCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl                                                             |
// | Scoreboard bench for hazard_ctrl. Two instances share the stimulus: one    |
// | with default parameters, one with LOAD_BUBBLES=3, MEM_TIMEOUT=4 and a      |
// | 4-bit stall counter. A behavioural model predicts each cycle's outputs.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        flush;
    logic        stall;
    logic        frz;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] idRs1, idRs2, idexregWrite;
  logic       idUse1, idUse2, idexR, exBranchTaken, memReq, memReady;

  logic        pc_a, ifid_a, flush_a, stall_a, frz_a, err_a;
  logic [15:0] cnt_a;
  logic        pc_b, ifid_b, flush_b, stall_b, frz_b, err_b;
  logic [3:0]  cnt_b;

  hazard_ctrl u_dut_a (
    .clk(clk), .reset(reset), .idRs1(idRs1), .idRs2(idRs2), .idUse1(idUse1),
    .idUse2(idUse2), .idexR(idexR), .idexregWrite(idexregWrite),
    .exBranchTaken(exBranchTaken), .memReq(memReq), .memReady(memReady),
    .pcWrite(pc_a), .ifidWrite(ifid_a), .ifidFlush(flush_a), .idexStall(stall_a),
    .freeze(frz_a), .memErr(err_a), .stallCount(cnt_a)
  );

  hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(4), .STALL_CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .idRs1(idRs1), .idRs2(idRs2), .idUse1(idUse1),
    .idUse2(idUse2), .idexR(idexR), .idexregWrite(idexregWrite),
    .exBranchTaken(exBranchTaken), .memReq(memReq), .memReady(memReady),
    .pcWrite(pc_b), .ifidWrite(ifid_b), .ifidFlush(flush_b), .idexStall(stall_b),
    .freeze(frz_b), .memErr(err_b), .stallCount(cnt_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state, per instance: bubbles still owed, whether a memory
  // wait is in progress and how many freeze cycles it has cost so far.
  int P_LB[2] = '{1, 3};
  int P_MT[2] = '{8, 4};
  int P_W[2]  = '{16, 4};
  int m_bub[2];
  int m_wc[2];
  bit m_wait[2];
  int m_cnt[2];

  function automatic bit reads_loaded_reg();
    if (!idexR || idexregWrite == 3'd0) return 1'b0;
    return (idUse1 && idRs1 == idexregWrite) || (idUse2 && idRs2 == idexregWrite);
  endfunction

  task automatic model_step(input int k, output exp_t e);
    bit busy;
    bit free_run;
    busy     = memReq && !memReady;
    free_run = 1'b0;
    e        = '0;
    e.pc     = 1'b1;
    e.ifid   = 1'b1;
    e.cnt    = 16'(m_cnt[k]);
    if (!reset) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.flush = 1'b1; e.stall = 1'b1; e.cnt = '0;
      m_bub[k] = 0; m_wait[k] = 1'b0; m_wc[k] = 0; m_cnt[k] = 0;
      return;
    end
    if (m_wait[k]) begin
      if (!busy) begin
        m_wait[k] = 1'b0;
        free_run  = 1'b1;
      end else if (m_wc[k] + 1 == P_MT[k]) begin
        e.err     = 1'b1;
        m_wait[k] = 1'b0;
      end else begin
        e.frz = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
        m_wc[k]++;
      end
    end else if (m_bub[k] > 0) begin
      e.pc = 1'b0; e.ifid = 1'b0;
      if (busy) e.frz = 1'b1;
      else begin
        e.stall = 1'b1;
        m_bub[k]--;
      end
    end else begin
      free_run = 1'b1;
    end
    if (free_run) begin
      if (busy) begin
        e.frz = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
        m_wait[k] = 1'b1; m_wc[k] = 1;
      end else if (exBranchTaken) begin
        e.flush = 1'b1; e.stall = 1'b1;
      end else if (reads_loaded_reg()) begin
        e.pc = 1'b0; e.ifid = 1'b0; e.stall = 1'b1;
        m_bub[k] = P_LB[k] - 1;
      end
    end
    if ((e.frz || e.stall || e.flush) && m_cnt[k] < (1 << P_W[k]) - 1) m_cnt[k]++;
  endtask

  task automatic set_in(input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic u1, input logic u2, input logic ld,
                        input logic [2:0] wr, input logic br,
                        input logic mq, input logic mr);
    idRs1 = rs1; idRs2 = rs2; idUse1 = u1; idUse2 = u2; idexR = ld;
    idexregWrite = wr; exBranchTaken = br; memReq = mq; memReady = mr;
  endtask

  task automatic idle();
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_in();
    set_in(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
  endtask

  // Inputs are already applied: predict this cycle, queue it, move to the
  // next cycle's drive point just after the rising edge.
  task automatic step(input int n = 1);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_step(0, e); q_a.push_back(e);
      model_step(1, e); q_b.push_back(e);
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        g = {pc_a, ifid_a, flush_a, stall_a, frz_a, err_a, cnt_a};
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL dut_a cyc %0d: got pc/ifid/fl/st/fz/er=%b cnt=%0d, want %b cnt=%0d",
                   cyc, g[21:16], g.cnt, e[21:16], e.cnt);
        end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        g = {pc_b, ifid_b, flush_b, stall_b, frz_b, err_b, 12'd0, cnt_b};
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL dut_b cyc %0d: got pc/ifid/fl/st/fz/er=%b cnt=%0d, want %b cnt=%0d",
                   cyc, g[21:16], g.cnt, e[21:16], e.cnt);
        end
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin rand_in(); step(); end
    reset = 1'b1;
    idle(); step(2);

    // Load-use on rs2, then the same with no destination register.
    set_in(3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0); step();
    idle(); step(4);
    set_in(3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); step();
    idle(); step(2);

    // Branch and load-use together.
    set_in(3'd5, 3'd1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0); step();
    idle(); step(3);

    // Memory wait released by memReady on the 4th cycle.
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0); step(3);
    memReady = 1'b1; step();
    idle(); step(2);

    // Timeout: memReady never comes.
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0); step(10);
    idle(); step(2);

    // Ready in the same cycle as the request: no freeze.
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1); step();
    idle(); step();

    // memReq dropped mid-wait, with a branch pending at release.
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0); step(2);
    memReq = 1'b0; step();
    idle(); step();

    // 20 consecutive flushes saturate the narrow counter.
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0); step(20);
    idle(); step();

    // Reset in the middle of a memory wait and of a load stall.
    set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0); step(2);
    reset = 1'b0; step();
    reset = 1'b1; idle(); step(2);
    set_in(3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0); step(2);
    reset = 1'b0; step();
    reset = 1'b1; idle(); step(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    idle();

    budget = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && budget < 10) begin
      @(negedge clk); #1;
      budget++;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, want 0", q_a.size(), q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
